// File: rtl/event_timer_core.sv
// Single-channel event timer: measures clocks between start and capture, holds the capture,
// and (when TIMER_ALARM_EN is defined) raises a one-shot alarm a programmed delay after start.
module event_timer_core #(
    parameter int TIMER_BITWIDTH = 32
) (
    input  logic                      clk,
    input  logic                      areset,
    input  logic                      sreset,
    input  logic                      start,
    input  logic                      capture,
    input  logic                      rst_capture,
    input  logic                      alarm_en,
    input  logic [TIMER_BITWIDTH-1:0] alarm_time,
    output logic [TIMER_BITWIDTH-1:0] capture_value,
    output logic                      capture_valid,
    output logic                      running,
    output logic                      overflow,
    output logic                      alarm,
    output logic                      alarm_armed
);

    localparam int W = TIMER_BITWIDTH;
    localparam logic [W-1:0] CNT_MAX = '1;

    // Handshake: start, capture, rst_capture and alarm_en are sampled on every rising edge
    // with no back-pressure; each asserted cycle is one request. Outputs are all registered.
    typedef enum logic {
        IDLE    = 1'b0,
        RUNNING = 1'b1
    } state_t;

    state_t         state;
    logic [W-1:0]   count;
    logic [W-1:0]   count_next;

    // Elapsed count as of the current edge; it saturates rather than wrapping.
    always_comb begin
        count_next = count;
        if (count != CNT_MAX) begin
            count_next = count + W'(1);
        end
    end

    assign running = (state == RUNNING);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state         <= IDLE;
            count         <= '0;
            capture_value <= '0;
            capture_valid <= 1'b0;
            overflow      <= 1'b0;
        end else if (sreset) begin
            state         <= IDLE;
            count         <= '0;
            capture_value <= '0;
            capture_valid <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            capture_valid <= 1'b0;
            if (rst_capture) begin
                state         <= IDLE;
                count         <= '0;
                capture_value <= '0;
                overflow      <= 1'b0;
            end else if (start) begin
                // A capture on the restart edge still reports the run being abandoned.
                if (state == RUNNING && capture) begin
                    capture_value <= count_next;
                    capture_valid <= 1'b1;
                end
                state    <= RUNNING;
                count    <= '0;
                overflow <= 1'b0;
            end else if (state == RUNNING) begin
                count <= count_next;
                if (count_next == CNT_MAX) begin
                    overflow <= 1'b1;
                end
                if (capture) begin
                    capture_value <= count_next;
                    capture_valid <= 1'b1;
                end
            end
        end
    end

`ifdef TIMER_ALARM_EN
    logic [W-1:0] alarm_reg;
    logic         alarm_hit;

    // Fires on the edge where elapsed equals the loaded delay; restarts re-base the match.
    assign alarm_hit = alarm_armed && (state == RUNNING) && !rst_capture && !start
                       && (count_next == alarm_reg);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            alarm_reg   <= '0;
            alarm_armed <= 1'b0;
            alarm       <= 1'b0;
        end else if (sreset) begin
            alarm_reg   <= '0;
            alarm_armed <= 1'b0;
            alarm       <= 1'b0;
        end else begin
            alarm <= 1'b0;
            if (alarm_en && (alarm_time != '0)) begin
                alarm_reg   <= alarm_time;
                alarm_armed <= 1'b1;
            end else if (alarm_hit) begin
                alarm       <= 1'b1;
                alarm_armed <= 1'b0;
            end
        end
    end
`else
    logic unused_alarm_inputs;
    assign unused_alarm_inputs = ^{alarm_en, alarm_time};
    assign alarm       = 1'b0;
    assign alarm_armed = 1'b0;
`endif

endmodule

// File: tb/tb_event_timer_core.sv
// Bench for event_timer_core: a 32-bit and an 8-bit copy share stimulus and are compared
// every cycle against an arithmetic model based on the start edge index.
module tb_event_timer_core;

    logic        clk = 1'b0;
    logic        areset, sreset, start, capture, rst_capture, alarm_en;
    logic [31:0] alarm_time;

    logic [31:0] cap32;
    logic        cv32, run32, ovf32, alm32, arm32;
    logic [7:0]  cap8;
    logic        cv8, run8, ovf8, alm8, arm8;

    int checks = 0;
    int errors = 0;

`ifdef TIMER_ALARM_EN
    localparam bit ALARM_ON = 1'b1;
`else
    localparam bit ALARM_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    event_timer_core u_dut32 (
        .clk(clk), .areset(areset), .sreset(sreset), .start(start), .capture(capture),
        .rst_capture(rst_capture), .alarm_en(alarm_en), .alarm_time(alarm_time),
        .capture_value(cap32), .capture_valid(cv32), .running(run32), .overflow(ovf32),
        .alarm(alm32), .alarm_armed(arm32)
    );

    event_timer_core #(.TIMER_BITWIDTH(8)) u_dut8 (
        .clk(clk), .areset(areset), .sreset(sreset), .start(start), .capture(capture),
        .rst_capture(rst_capture), .alarm_en(alarm_en), .alarm_time(alarm_time[7:0]),
        .capture_value(cap8), .capture_valid(cv8), .running(run8), .overflow(ovf8),
        .alarm(alm8), .alarm_armed(arm8)
    );

    // Reference model: index 0 is the 32-bit copy, index 1 the 8-bit copy.
    longint maxv[2] = '{64'hFFFF_FFFF, 64'd255};
    longint cyc = 0;
    bit     m_run[2], m_cv[2], m_ovf[2], m_alarm[2], m_armed[2];
    longint m_s[2], m_cap[2], m_atime[2];

    function automatic void model_reset(int i);
        m_run[i] = 0; m_cv[i] = 0; m_ovf[i] = 0; m_alarm[i] = 0; m_armed[i] = 0;
        m_s[i] = 0; m_cap[i] = 0; m_atime[i] = 0;
    endfunction

    function automatic longint elapsed(int i);
        longint e = cyc - m_s[i];
        return (e > maxv[i]) ? maxv[i] : e;
    endfunction

    function automatic void model_edge(int i, bit sr, bit rc, bit st, bit cp, bit ae,
                                       longint at);
        longint e;
        bit ae_eff, fire;
        m_cv[i] = 0;
        m_alarm[i] = 0;
        if (sr) begin
            model_reset(i);
            return;
        end
        e = elapsed(i);
        ae_eff = ALARM_ON && ae && ((at & maxv[i]) != 0);
        fire = ALARM_ON && m_armed[i] && m_run[i] && !rc && !st && !ae_eff
               && (e == m_atime[i]);
        if (rc) begin
            m_run[i] = 0; m_cap[i] = 0; m_ovf[i] = 0;
        end else if (st) begin
            if (m_run[i] && cp) begin
                m_cap[i] = e; m_cv[i] = 1;
            end
            m_run[i] = 1; m_s[i] = cyc; m_ovf[i] = 0;
        end else if (m_run[i]) begin
            if (e >= maxv[i]) m_ovf[i] = 1;
            if (cp) begin
                m_cap[i] = e; m_cv[i] = 1;
            end
        end
        if (ae_eff) begin
            m_atime[i] = at & maxv[i];
            m_armed[i] = 1;
        end else if (fire) begin
            m_alarm[i] = 1;
            m_armed[i] = 0;
        end
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        chk("cap32", 64'(cap32), m_cap[0]);
        chk("cv32", 64'(cv32), 64'(m_cv[0]));
        chk("run32", 64'(run32), 64'(m_run[0]));
        chk("ovf32", 64'(ovf32), 64'(m_ovf[0]));
        chk("alarm32", 64'(alm32), 64'(m_alarm[0]));
        chk("armed32", 64'(arm32), 64'(m_armed[0]));
        chk("cap8", 64'(cap8), m_cap[1]);
        chk("cv8", 64'(cv8), 64'(m_cv[1]));
        chk("run8", 64'(run8), 64'(m_run[1]));
        chk("ovf8", 64'(ovf8), 64'(m_ovf[1]));
        chk("alarm8", 64'(alm8), 64'(m_alarm[1]));
        chk("armed8", 64'(arm8), 64'(m_armed[1]));
    endtask

    // Drives one cycle of inputs, lets the edge happen, advances the model, checks.
    task automatic step(bit sr, bit rc, bit st, bit cp, bit ae, logic [31:0] at);
        sreset = sr; rst_capture = rc; start = st; capture = cp; alarm_en = ae;
        alarm_time = at;
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) model_edge(i, sr, rc, st, cp, ae, longint'(at));
        #1;
        check_all();
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 32'd0);
    endtask

    initial begin
        areset = 1; sreset = 0; start = 0; capture = 0; rst_capture = 0;
        alarm_en = 0; alarm_time = 0;
        for (int i = 0; i < 2; i++) model_reset(i);

        // Reset: areset for 100 ns, then one sreset cycle.
        #100;
        areset = 0;
        #1;
        check_all();
        step(1, 0, 0, 0, 0, 32'd0);
        chk("t1_running", 64'(run32), 64'd0);
        chk("t1_cap", 64'(cap32), 64'd0);

        // Single measurement of 1000 clocks.
        step(0, 0, 1, 0, 0, 32'd0);
        idle(999);
        step(0, 0, 0, 1, 0, 32'd0);
        chk("t2_cap", 64'(cap32), 64'd1000);
        chk("t2_valid", 64'(cv32), 64'd1);
        idle(1);
        chk("t2_valid_drop", 64'(cv32), 64'd0);

        // Two captures in one run.
        step(0, 1, 0, 0, 0, 32'd0);
        step(0, 0, 1, 0, 0, 32'd0);
        idle(99);
        step(0, 0, 0, 1, 0, 32'd0);
        chk("t3_cap1", 64'(cap32), 64'd100);
        idle(49);
        step(0, 0, 0, 1, 0, 32'd0);
        chk("t3_cap2", 64'(cap32), 64'd150);
        chk("t3_running", 64'(run32), 64'd1);

        // rst_capture mid-run, then a fresh measurement; capture in IDLE ignored.
        step(0, 0, 1, 0, 0, 32'd0);
        idle(49);
        step(0, 1, 0, 0, 0, 32'd0);
        chk("t4_idle", 64'(run32), 64'd0);
        step(0, 0, 0, 1, 0, 32'd0);
        chk("t4_ignored", 64'(cv32), 64'd0);
        step(0, 0, 1, 0, 0, 32'd0);
        idle(180);
        step(0, 0, 0, 1, 0, 32'd0);
        chk("t4_cap", 64'(cap32), 64'd181);

        // Saturation on the 8-bit copy, cleared by start; start+capture same edge.
        step(0, 0, 1, 0, 0, 32'd0);
        idle(299);
        step(0, 0, 1, 1, 0, 32'd0);
        chk("t6_cap32", 64'(cap32), 64'd300);
        chk("t6_cap8", 64'(cap8), 64'd255);
        chk("t6_ovf8_cleared", 64'(ovf8), 64'd0);
        idle(299);
        chk("t6_ovf8", 64'(ovf8), 64'd1);
        step(0, 0, 1, 0, 0, 32'd0);
        chk("t6_ovf8_start", 64'(ovf8), 64'd0);

        // Alarm 500 clocks after start; no repeat; zero delay ignored.
        step(0, 1, 0, 0, 0, 32'd0);
        step(0, 0, 0, 0, 1, 32'd500);
        chk("t5_armed", 64'(arm32), 64'(ALARM_ON));
        step(0, 0, 1, 0, 0, 32'd0);
        idle(499);
        chk("t5_early", 64'(alm32), 64'd0);
        step(0, 0, 0, 0, 0, 32'd0);
        chk("t5_alarm", 64'(alm32), 64'(ALARM_ON));
        chk("t5_disarm", 64'(arm32), 64'd0);
        idle(600);
        step(0, 0, 0, 0, 1, 32'd0);
        chk("t5_zero", 64'(arm32), 64'd0);
        step(0, 0, 1, 0, 0, 32'd0);
        idle(300);

        // Asynchronous reset between edges.
        areset = 1;
        #2;
        for (int i = 0; i < 2; i++) model_reset(i);
        check_all();
        areset = 0;
        idle(2);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 149) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 300)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
